// File: rtl/mips_cpu_instr_memory.sv
// mips_cpu_instr_memory
//   Instruction-memory responder for the Harvard CPU fetch port. A program is
//   streamed in through the load_* handshake, where words land at consecutive
//   addresses from BASE_ADDR. After load_last arrives, or capacity is reached,
//   the fetch port goes live and the CPU is released from reset.
//
// Ports
//   clk_i             system clock, rising edge
//   reset_i           asynchronous active-high reset
//   instr_address_i   CPU fetch byte address
//   instr_readdata_o  fetched word (combinational, zero latency)
//   load_start_i      begin/restart a program load
//   load_valid_i      load_data_i valid this cycle
//   load_last_i       final program word (qualified by load_valid_i)
//   load_data_i       program word
//   load_ready_o      loader accepts a word this cycle (LOAD state)
//   load_done_o       program loaded, fetch port live
//   load_count_o      number of words loaded
//   load_truncated_o  sticky: capacity reached before load_last_i
//   addr_fault_o      sticky: illegal fetch seen while live
//   cpu_hold_o        hold the CPU in reset
module mips_cpu_instr_memory #(
  parameter logic [31:0] BASE_ADDR  = 32'hBFC00000,
  parameter int          DEPTH_LOG2 = 8,
  parameter logic [31:0] NOP_WORD   = 32'h00000000
) (
  input  logic                  clk_i,
  input  logic                  reset_i,
  input  logic [31:0]           instr_address_i,
  output logic [31:0]           instr_readdata_o,
  input  logic                  load_start_i,
  input  logic                  load_valid_i,
  input  logic                  load_last_i,
  input  logic [31:0]           load_data_i,
  output logic                  load_ready_o,
  output logic                  load_done_o,
  output logic [DEPTH_LOG2:0]   load_count_o,
  output logic                  load_truncated_o,
  output logic                  addr_fault_o,
  output logic                  cpu_hold_o
);

  localparam int DEPTH = 1 << DEPTH_LOG2;

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_LIVE} state_e;

  state_e                state_q;
  logic [DEPTH_LOG2-1:0] ptr_q, ptr_d;
  logic [DEPTH_LOG2:0]   count_q, count_d;
  logic                  ready_q, done_q, hold_q, trunc_q, fault_q;
  logic [31:0]           mem_q [DEPTH];

  // Read path
  logic [31:0]           off;
  logic [DEPTH_LOG2-1:0] idx;
  logic                  in_range, legal, wr_en;

  // Offset wraps, so addresses below BASE_ADDR land far out of range.
  assign off      = instr_address_i - BASE_ADDR;
  assign idx      = off[DEPTH_LOG2+1:2];
  assign in_range = (off >> (DEPTH_LOG2 + 2)) == 32'd0;
  assign legal    = (state_q == S_LIVE) && (off[1:0] == 2'b00) && in_range &&
                    ({1'b0, idx} < count_q);

  assign instr_readdata_o = legal ? mem_q[idx] : NOP_WORD;

  assign ptr_d   = ptr_q + {{(DEPTH_LOG2-1){1'b0}}, 1'b1};
  assign count_d = count_q + {{DEPTH_LOG2{1'b0}}, 1'b1};

  // A load_start on the same cycle as a load word wins, so that word is dropped.
  assign wr_en = (state_q == S_LOAD) && load_valid_i && !load_start_i;

  // Storage is never reset. Stale words stay unreachable because count_q gates reads.
  always_ff @(posedge clk_i) begin
    if (wr_en) mem_q[ptr_q] <= load_data_i;
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q <= S_IDLE;
      ptr_q   <= '0;
      count_q <= '0;
      ready_q <= 1'b0;
      done_q  <= 1'b0;
      hold_q  <= 1'b1;
      trunc_q <= 1'b0;
      fault_q <= 1'b0;
    end else begin
      if (load_start_i) begin
        // Start/restart from any state: clear pointer, count and flags.
        state_q <= S_LOAD;
        ptr_q   <= '0;
        count_q <= '0;
        ready_q <= 1'b1;
        done_q  <= 1'b0;
        hold_q  <= 1'b1;
        trunc_q <= 1'b0;
        fault_q <= 1'b0;
      end else begin
        case (state_q)
          S_LOAD: begin
            if (load_valid_i) begin
              ptr_q   <= ptr_d;
              count_q <= count_d;
              if (load_last_i || (&ptr_q)) begin
                state_q <= S_LIVE;
                ready_q <= 1'b0;
                done_q  <= 1'b1;
                hold_q  <= 1'b0;
                // Full array without a last marker means the program was cut short.
                if (!load_last_i) trunc_q <= 1'b1;
              end
            end
          end
          S_LIVE: begin
            // Address 0 is the CPU halt/return target, not a fault.
            if ((instr_address_i != 32'd0) && !legal) fault_q <= 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

  assign load_ready_o     = ready_q;
  assign load_done_o      = done_q;
  assign cpu_hold_o       = hold_q;
  assign load_count_o     = count_q;
  assign load_truncated_o = trunc_q;
  assign addr_fault_o     = fault_q;

endmodule

// File: tb/tb_mips_cpu_instr_memory.sv
module tb_mips_cpu_instr_memory;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  // DUT 1: default 256-word instance
  logic [31:0] addr, rd;
  logic        start, valid, last;
  logic [31:0] data;
  logic        ready, done, trunc, fault, hold;
  logic [8:0]  count;

  // DUT 2: 4-word instance for truncation
  logic [31:0] addr2, rd2;
  logic        start2, valid2, last2;
  logic [31:0] data2;
  logic        ready2, done2, trunc2, fault2, hold2;
  logic [2:0]  count2;

  int checks = 0;
  int errors = 0;

  mips_cpu_instr_memory dut (
    .clk_i(clk), .reset_i(reset), .instr_address_i(addr), .instr_readdata_o(rd),
    .load_start_i(start), .load_valid_i(valid), .load_last_i(last), .load_data_i(data),
    .load_ready_o(ready), .load_done_o(done), .load_count_o(count),
    .load_truncated_o(trunc), .addr_fault_o(fault), .cpu_hold_o(hold)
  );

  mips_cpu_instr_memory #(.DEPTH_LOG2(2)) dut2 (
    .clk_i(clk), .reset_i(reset), .instr_address_i(addr2), .instr_readdata_o(rd2),
    .load_start_i(start2), .load_valid_i(valid2), .load_last_i(last2), .load_data_i(data2),
    .load_ready_o(ready2), .load_done_o(done2), .load_count_o(count2),
    .load_truncated_o(trunc2), .addr_fault_o(fault2), .cpu_hold_o(hold2)
  );

  // Drive one word into DUT 1 for one cycle; leaves inputs idle afterwards.
  task automatic push(input logic [31:0] w, input logic l);
    valid = 1'b1; data = w; last = l;
    @(negedge clk);
    valid = 1'b0; last = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    addr = 32'h0; start = 0; valid = 0; last = 0; data = 0;
    addr2 = 32'h0; start2 = 0; valid2 = 0; last2 = 0; data2 = 0;
    @(negedge clk);
    checks++;
    if ({ready, done, hold, trunc, fault} !== 5'b00100 || count !== 9'd0 || rd !== 32'h0) begin
      errors++;
      $display("FAIL reset_dut1: rdy/done/hold/trunc/fault=%b count=%0d rd=%h, want 00100 0 0",
               {ready, done, hold, trunc, fault}, count, rd);
    end
    checks++;
    if ({ready2, done2, hold2, trunc2, fault2} !== 5'b00100 || count2 !== 3'd0) begin
      errors++;
      $display("FAIL reset_dut2: flags=%b count=%0d, want 00100 0",
               {ready2, done2, hold2, trunc2, fault2}, count2);
    end
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_basic_load();
    pulse_start();
    checks++;
    if (ready !== 1'b1 || done !== 1'b0 || count !== 9'd0) begin
      errors++;
      $display("FAIL load_enter: ready=%b done=%b count=%0d, want 1 0 0", ready, done, count);
    end
    push(32'h2484FFFF, 1'b0);
    // idle cycle: state holds, nothing written
    @(negedge clk);
    checks++;
    if (ready !== 1'b1 || count !== 9'd1) begin
      errors++;
      $display("FAIL load_idle_hold: ready=%b count=%0d, want 1 1", ready, count);
    end
    push(32'h00042400, 1'b0);
    checks++;
    if (ready !== 1'b1 || done !== 1'b0 || hold !== 1'b1) begin
      errors++;
      $display("FAIL load_third_ready: ready=%b done=%b hold=%b, want 1 0 1", ready, done, hold);
    end
    push(32'h2484FFB3, 1'b1);
    checks++;
    if (done !== 1'b1 || hold !== 1'b0 || ready !== 1'b0 || count !== 9'd3 || trunc !== 1'b0) begin
      errors++;
      $display("FAIL load_done: done=%b hold=%b ready=%b count=%0d trunc=%b, want 1 0 0 3 0",
               done, hold, ready, count, trunc);
    end
  endtask

  task automatic test_fetch();
    addr = 32'hBFC00008; #1;
    checks++;
    if (rd !== 32'h2484FFB3) begin
      errors++; $display("FAIL fetch_w2: got %h want 2484ffb3", rd);
    end
    addr = 32'hBFC00000; #1;
    checks++;
    if (rd !== 32'h2484FFFF) begin
      errors++; $display("FAIL fetch_w0: got %h want 2484ffff", rd);
    end
    @(negedge clk);
    checks++;
    if (fault !== 1'b0) begin
      errors++; $display("FAIL fetch_no_fault: fault=%b want 0", fault);
    end
    addr = 32'hBFC0000C; #1;
    checks++;
    if (rd !== 32'h0) begin
      errors++; $display("FAIL fetch_beyond_count: got %h want 00000000", rd);
    end
    @(negedge clk);
    checks++;
    if (fault !== 1'b1) begin
      errors++; $display("FAIL fault_beyond_count: fault=%b want 1", fault);
    end
    addr = 32'hBFBFFFFC; #1;
    checks++;
    if (rd !== 32'h0) begin
      errors++; $display("FAIL fetch_below_base: got %h want 00000000", rd);
    end
    addr = 32'hBFC00400; #1;
    checks++;
    if (rd !== 32'h0) begin
      errors++; $display("FAIL fetch_past_cap: got %h want 00000000", rd);
    end
  endtask

  task automatic test_halt_misalign();
    // Reload clears the sticky fault.
    addr = 32'h0;
    pulse_start();
    checks++;
    if (fault !== 1'b0 || count !== 9'd0) begin
      errors++; $display("FAIL restart_clear: fault=%b count=%0d want 0 0", fault, count);
    end
    push(32'h2484FFFF, 1'b0);
    push(32'h00042400, 1'b0);
    push(32'h2484FFB3, 1'b1);
    #1;
    checks++;
    if (rd !== 32'h0) begin
      errors++; $display("FAIL halt_rd: got %h want 00000000", rd);
    end
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (fault !== 1'b0 || done !== 1'b1) begin
      errors++; $display("FAIL halt_no_fault: fault=%b done=%b want 0 1", fault, done);
    end
    addr = 32'hBFC00002; #1;
    checks++;
    if (rd !== 32'h0) begin
      errors++; $display("FAIL misalign_rd: got %h want 00000000", rd);
    end
    @(negedge clk);
    checks++;
    if (fault !== 1'b1) begin
      errors++; $display("FAIL misalign_fault: fault=%b want 1", fault);
    end
  endtask

  task automatic test_restart();
    addr = 32'hBFC00000; #1;
    checks++;
    if (rd !== 32'h2484FFFF) begin
      errors++; $display("FAIL live_pre_restart: got %h want 2484ffff", rd);
    end
    pulse_start();
    checks++;
    if (rd !== 32'h0 || ready !== 1'b1 || fault !== 1'b0) begin
      errors++; $display("FAIL live_to_load: rd=%h ready=%b fault=%b want 0 1 0", rd, ready, fault);
    end
    push(32'hAAAA0001, 1'b0);
    push(32'hAAAA0002, 1'b0);
    // start with a valid word in the same cycle: the word is discarded
    start = 1'b1; valid = 1'b1; data = 32'hDEADBEEF;
    @(negedge clk);
    start = 1'b0; valid = 1'b0;
    checks++;
    if (count !== 9'd0 || ready !== 1'b1 || done !== 1'b0) begin
      errors++; $display("FAIL restart_drop: count=%0d ready=%b done=%b want 0 1 0", count, ready, done);
    end
    push(32'h11111111, 1'b0);
    push(32'h22222222, 1'b1);
    checks++;
    if (count !== 9'd2 || done !== 1'b1) begin
      errors++; $display("FAIL restart_load: count=%0d done=%b want 2 1", count, done);
    end
    addr = 32'hBFC00000; #1;
    checks++;
    if (rd !== 32'h11111111) begin
      errors++; $display("FAIL restart_w0: got %h want 11111111", rd);
    end
    addr = 32'hBFC00004; #1;
    checks++;
    if (rd !== 32'h22222222) begin
      errors++; $display("FAIL restart_w1: got %h want 22222222", rd);
    end
    addr = 32'hBFC00008; #1;
    checks++;
    if (rd !== 32'h0) begin
      errors++; $display("FAIL restart_w2_stale: got %h want 00000000", rd);
    end
    addr = 32'hBFC00000;
    @(negedge clk);
  endtask

  task automatic test_truncation();
    logic [31:0] w [5];
    w[0] = 32'hC0DE0000; w[1] = 32'hC0DE0001; w[2] = 32'hC0DE0002;
    w[3] = 32'hC0DE0003; w[4] = 32'hC0DE0004;
    start2 = 1'b1;
    @(negedge clk);
    start2 = 1'b0;
    for (int i = 0; i < 5; i++) begin
      valid2 = 1'b1; data2 = w[i]; last2 = 1'b0;
      checks++;
      if (ready2 !== (i < 4)) begin
        errors++; $display("FAIL trunc_ready_%0d: ready=%b want %b", i, ready2, (i < 4));
      end
      @(negedge clk);
    end
    valid2 = 1'b0;
    checks++;
    if (trunc2 !== 1'b1 || done2 !== 1'b1 || count2 !== 3'd4 || hold2 !== 1'b0) begin
      errors++; $display("FAIL trunc_state: trunc=%b done=%b count=%0d hold=%b want 1 1 4 0",
                         trunc2, done2, count2, hold2);
    end
    addr2 = 32'hBFC00000; #1;
    checks++;
    if (rd2 !== 32'hC0DE0000) begin
      errors++; $display("FAIL trunc_w0: got %h want c0de0000 (5th word must not wrap)", rd2);
    end
    addr2 = 32'hBFC0000C; #1;
    checks++;
    if (rd2 !== 32'hC0DE0003) begin
      errors++; $display("FAIL trunc_w3: got %h want c0de0003", rd2);
    end
    addr2 = 32'hBFC00010; #1;
    checks++;
    if (rd2 !== 32'h0) begin
      errors++; $display("FAIL trunc_past_cap: got %h want 00000000", rd2);
    end
    addr2 = 32'h0;
    @(negedge clk);
  endtask

  task automatic test_async_reset();
    addr = 32'hBFC00000; #1;
    checks++;
    if (rd !== 32'h11111111 || done !== 1'b1) begin
      errors++; $display("FAIL pre_reset_live: rd=%h done=%b want 11111111 1", rd, done);
    end
    #2 reset = 1'b1;
    #1;
    checks++;
    if (done !== 1'b0 || hold !== 1'b1 || rd !== 32'h0 || count !== 9'd0) begin
      errors++; $display("FAIL async_reset: done=%b hold=%b rd=%h count=%0d want 0 1 0 0",
                         done, hold, rd, count);
    end
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if (rd !== 32'h0 || ready !== 1'b0 || done !== 1'b0) begin
      errors++; $display("FAIL post_reset_idle: rd=%h ready=%b done=%b want 0 0 0", rd, ready, done);
    end
  endtask

  initial begin
    test_reset();
    test_basic_load();
    test_fetch();
    test_halt_misalign();
    test_restart();
    test_truncation();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
